mem_port_arb: RTL and testbench

Two-requester arbiter that shares one port of the byte-addressable 32-bit data RAM (`dpram_32_ba` port 0 or 1) between an instruction-fetch requester (r0) and a load/store requester (r1). It forwards the granted request to the RAM port unchanged and routes each 1-cycle-latency read response back to the requester that issued it. Each requester has a one-entry response skid buffer, so a requester that stalls its response channel never blocks the other requester.

---
 rtl/mem_port_arb_pkg.sv | 19 +
 rtl/mem_port_arb_if.sv | 39 +++
 rtl/mem_port_arb_rsp_skid.sv | 33 +++
 rtl/mem_port_arb.sv | 120 ++++++++++++
 tb/tb_mem_port_arb.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic req_id_t;

    // Byte-lane merge used wherever a masked write meets existing word contents.
    function automatic logic [3:0][7:0] merge_bytes(input logic [3:0][7:0] old_w,
                                                    input logic [3:0][7:0] new_w,
                                                    input logic [3:0]      mask);
        logic [3:0][7:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b] = mask[b] ? new_w[b] : old_w[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of both requester channels and the RAM port; slave = arbiter side.
interface mem_port_arb_if #(parameter int DEPTH = 8192);

    localparam int AW = $clog2(DEPTH) + 2;

    logic                t_r0_valid, t_r1_valid;
    logic                t_r0_ready, t_r1_ready;
    logic                t_r0_we, t_r1_we;
    logic [AW-1:0]       t_r0_addr, t_r1_addr;
    logic [3:0][7:0]     t_r0_data, t_r1_data;
    logic [3:0]          t_r0_mask, t_r1_mask;
    logic                i_r0_valid, i_r1_valid;
    logic                i_r0_ready, i_r1_ready;
    logic [3:0][7:0]     i_r0_data, i_r1_data;

    logic                i_mem_valid, i_mem_we, i_mem_ready;
    logic [AW-1:0]       i_mem_addr;
    logic [3:0][7:0]     i_mem_data;
    logic [3:0]          i_mem_mask;
    logic                t_mem_valid, t_mem_ready;
    logic [3:0][7:0]     t_mem_data;

    modport slave (
        input  t_r0_valid, t_r1_valid, t_r0_we, t_r1_we, t_r0_addr, t_r1_addr,
               t_r0_data, t_r1_data, t_r0_mask, t_r1_mask, i_r0_ready, i_r1_ready,
               i_mem_ready, t_mem_valid, t_mem_data,
        output t_r0_ready, t_r1_ready, i_r0_valid, i_r1_valid, i_r0_data, i_r1_data,
               i_mem_valid, i_mem_we, i_mem_addr, i_mem_data, i_mem_mask, t_mem_ready
    );

    modport master (
        output t_r0_valid, t_r1_valid, t_r0_we, t_r1_we, t_r0_addr, t_r1_addr,
               t_r0_data, t_r1_data, t_r0_mask, t_r1_mask, i_r0_ready, i_r1_ready,
               i_mem_ready, t_mem_valid, t_mem_data,
        input  t_r0_ready, t_r1_ready, i_r0_valid, i_r1_valid, i_r0_data, i_r1_data,
               i_mem_valid, i_mem_we, i_mem_addr, i_mem_data, i_mem_mask, t_mem_ready
    );

endinterface

// File: rtl/mem_port_arb_rsp_skid.sv
// One-entry response skid buffer: passes the RAM response straight through, holds it when stalled.
module mem_arb_rsp_skid (
    input  logic            clk,
    input  logic            rstf,
    input  logic            i_present,
    input  logic [3:0][7:0] i_data,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [3:0][7:0] o_data,
    output logic            o_buf_v
);

    logic            r_buf_v;
    logic [3:0][7:0] r_buf_data;

    // The arbiter never issues a new read while the buffer is full, so present and buffered never collide.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            r_buf_v    <= 1'b0;
            r_buf_data <= '0;
        end else if (r_buf_v) begin
            if (i_ready) r_buf_v <= 1'b0;
        end else if (i_present && !i_ready) begin
            r_buf_v    <= 1'b1;
            r_buf_data <= i_data;
        end
    end

    assign o_valid = r_buf_v | i_present;
    assign o_data  = r_buf_v ? r_buf_data : i_data;
    assign o_buf_v = r_buf_v;

endmodule

// File: rtl/mem_port_arb.sv
// Shares one RAM port between fetch (r0) and load/store (r1); define MEM_ARB_RR_EN for round-robin.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 8192
) (
    input  logic           clk,
    input  logic           rstf,
    mem_port_arb_if.slave  bus
);

    localparam int AW = $clog2(DEPTH) + 2;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [3:0][7:0] data;
        logic [3:0]      mask;
    } mem_req_t;

    mem_req_t             w_req [NUM_REQ];
    mem_req_t             w_sel_req;
    logic [NUM_REQ-1:0]   w_req_valid, w_rsp_ready, w_rsp_valid, w_buf_v;
    logic [NUM_REQ-1:0]   w_elig, w_grant, w_present;
    logic [3:0][7:0]      w_rsp_data [NUM_REQ];
    req_id_t              w_sel_id;
    logic                 w_any, w_hs;

    logic                 r_inflight;
    req_id_t              r_rsp_id;

    always_comb begin
        w_req[0]    = '{we: bus.t_r0_we, addr: bus.t_r0_addr, data: bus.t_r0_data, mask: bus.t_r0_mask};
        w_req[1]    = '{we: bus.t_r1_we, addr: bus.t_r1_addr, data: bus.t_r1_data, mask: bus.t_r1_mask};
        w_req_valid = {bus.t_r1_valid, bus.t_r0_valid};
        w_rsp_ready = {bus.i_r1_ready, bus.i_r0_ready};
    end

    // A read is only eligible if its response has a guaranteed landing spot next cycle; reset masks all requests.
    always_comb begin
        w_elig = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_elig[k] = rstf & w_req_valid[k] &
                        (w_req[k].we | (!w_buf_v[k] &
                         (!(r_inflight && (r_rsp_id == req_id_t'(k))) | w_rsp_ready[k])));
        end
    end

    assign w_any = |w_elig;
    assign w_hs  = w_any & bus.i_mem_ready;

`ifdef MEM_ARB_RR_EN
    req_id_t r_last;

    always_comb begin
        if (&w_elig) w_sel_id = ~r_last;
        else         w_sel_id = req_id_t'(w_elig[1]);
    end

    // Resetting to r1 as last winner gives r0 the first tie.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf)     r_last <= 1'b1;
        else if (w_hs) r_last <= w_sel_id;
    end
`else
    assign w_sel_id = req_id_t'(!w_elig[0] && w_elig[1]);
`endif

    always_comb begin
        w_grant           = '0;
        w_grant[w_sel_id] = w_any;
        w_sel_req         = w_req[w_sel_id];
    end

    assign bus.i_mem_valid = w_any;
    assign bus.i_mem_we    = w_sel_req.we;
    assign bus.i_mem_addr  = w_sel_req.addr;
    assign bus.i_mem_data  = w_sel_req.data;
    assign bus.i_mem_mask  = w_sel_req.mask;
    assign bus.t_mem_ready = 1'b1;
    assign bus.t_r0_ready  = w_grant[0] & bus.i_mem_ready;
    assign bus.t_r1_ready  = w_grant[1] & bus.i_mem_ready;

    // The RAM's valid is not reset, so a response is only trusted while a read is known to be outstanding.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            r_inflight <= 1'b0;
            r_rsp_id   <= 1'b0;
        end else begin
            r_inflight <= w_hs & !w_sel_req.we;
            if (w_hs && !w_sel_req.we) r_rsp_id <= w_sel_id;
        end
    end

    always_comb begin
        w_present = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_present[k] = bus.t_mem_valid & r_inflight & (r_rsp_id == req_id_t'(k));
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_skid
        mem_arb_rsp_skid u_skid (
            .clk       (clk),
            .rstf      (rstf),
            .i_present (w_present[k]),
            .i_data    (bus.t_mem_data),
            .i_ready   (w_rsp_ready[k]),
            .o_valid   (w_rsp_valid[k]),
            .o_data    (w_rsp_data[k]),
            .o_buf_v   (w_buf_v[k])
        );
    end

    assign bus.i_r0_valid = w_rsp_valid[0];
    assign bus.i_r1_valid = w_rsp_valid[1];
    assign bus.i_r0_data  = w_rsp_data[0];
    assign bus.i_r1_data  = w_rsp_data[1];

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a 1-cycle-latency byte-masked RAM model.
module tb_mem_port_arb;
    import mem_arb_pkg::*;

    localparam int DEPTH = 8192;
    localparam int AW    = $clog2(DEPTH) + 2;

    logic clk;
    logic rstf;
    int   nPass;
    int   nTotal;

    logic          preEn;
    logic [AW-1:0] preAddr;
    logic [31:0]   preData;
    logic [31:0]   ramModel [DEPTH];

    mem_port_arb_if #(.DEPTH(DEPTH)) bus ();

    mem_port_arb #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstf (rstf),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: masked writes, reads answer one cycle later; its valid has no reset.
    always @(posedge clk) begin
        if (preEn) begin
            ramModel[preAddr[AW-1:2]] <= preData;
            bus.t_mem_valid <= 1'b0;
        end else if (bus.i_mem_valid && bus.i_mem_ready) begin
            if (bus.i_mem_we) begin
                ramModel[bus.i_mem_addr[AW-1:2]] <=
                    merge_bytes(ramModel[bus.i_mem_addr[AW-1:2]], bus.i_mem_data, bus.i_mem_mask);
                bus.t_mem_valid <= 1'b0;
            end else begin
                bus.t_mem_data  <= ramModel[bus.i_mem_addr[AW-1:2]];
                bus.t_mem_valid <= 1'b1;
            end
        end else begin
            bus.t_mem_valid <= 1'b0;
        end
    end

    task automatic idleReqs();
        bus.t_r0_valid = 1'b0; bus.t_r0_we = 1'b0; bus.t_r0_addr = '0; bus.t_r0_data = '0; bus.t_r0_mask = 4'hF;
        bus.t_r1_valid = 1'b0; bus.t_r1_we = 1'b0; bus.t_r1_addr = '0; bus.t_r1_data = '0; bus.t_r1_mask = 4'hF;
        bus.i_r0_ready = 1'b1; bus.i_r1_ready = 1'b1;
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [31:0] data);
        @(negedge clk);
        preEn = 1'b1; preAddr = addr; preData = data;
        @(negedge clk);
        preEn = 1'b0;
    endtask

    task automatic initMemory();
        preload(15'h0010, 32'hDEADBEEF);
        preload(15'h0020, 32'h01234567);
        preload(15'h0040, 32'h11223344);
        preload(15'h0080, 32'hCAFEF00D);
        preload(15'h0084, 32'h12345678);
        preload(15'h0090, 32'h0BADC0DE);
        preload(15'h00A0, 32'h5A5A5A5A);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.t_r0_valid = 1'($urandom); bus.t_r0_we = 1'($urandom); bus.t_r0_addr = AW'($urandom);
            bus.t_r1_valid = 1'($urandom); bus.t_r1_we = 1'($urandom); bus.t_r1_addr = AW'($urandom);
            bus.i_r0_ready = 1'($urandom); bus.i_r1_ready = 1'($urandom);
            #2;
            nTotal++; if (bus.i_r0_valid !== 1'b0) $display("[TB] FAIL rst_r0_valid c%0d: got %b want 0", c, bus.i_r0_valid); else nPass++;
            nTotal++; if (bus.i_r1_valid !== 1'b0) $display("[TB] FAIL rst_r1_valid c%0d: got %b want 0", c, bus.i_r1_valid); else nPass++;
            nTotal++; if (bus.i_mem_valid !== 1'b0) $display("[TB] FAIL rst_mem_valid c%0d: got %b want 0", c, bus.i_mem_valid); else nPass++;
        end
        @(negedge clk);
        idleReqs();
        rstf = 1'b1;
        #2;
        nTotal++; if (bus.i_mem_valid !== 1'b0) $display("[TB] FAIL rst_idle_mem_valid: got %b want 0", bus.i_mem_valid); else nPass++;
    endtask

    task automatic test_contending_reads();
        @(negedge clk);
        bus.t_r0_valid = 1'b1; bus.t_r0_we = 1'b0; bus.t_r0_addr = 15'h0010;
        bus.t_r1_valid = 1'b1; bus.t_r1_we = 1'b0; bus.t_r1_addr = 15'h0020;
        #2;
        nTotal++; if (bus.t_r0_ready !== 1'b1) $display("[TB] FAIL ctn_r0_ready_c0: got %b want 1", bus.t_r0_ready); else nPass++;
        nTotal++; if (bus.t_r1_ready !== 1'b0) $display("[TB] FAIL ctn_r1_ready_c0: got %b want 0", bus.t_r1_ready); else nPass++;
        nTotal++; if (bus.i_mem_addr !== 15'h0010) $display("[TB] FAIL ctn_addr_c0: got %h want 0010", bus.i_mem_addr); else nPass++;
        @(negedge clk);
        bus.t_r0_valid = 1'b0;
        #2;
        nTotal++; if (bus.i_r0_valid !== 1'b1) $display("[TB] FAIL ctn_r0_valid_c1: got %b want 1", bus.i_r0_valid); else nPass++;
        nTotal++; if (bus.i_r0_data !== 32'hDEADBEEF) $display("[TB] FAIL ctn_r0_data_c1: got %h want deadbeef", bus.i_r0_data); else nPass++;
        nTotal++; if (bus.t_r1_ready !== 1'b1) $display("[TB] FAIL ctn_r1_ready_c1: got %b want 1", bus.t_r1_ready); else nPass++;
        nTotal++; if (bus.i_mem_addr !== 15'h0020) $display("[TB] FAIL ctn_addr_c1: got %h want 0020", bus.i_mem_addr); else nPass++;
        @(negedge clk);
        bus.t_r1_valid = 1'b0;
        #2;
        nTotal++; if (bus.i_r1_valid !== 1'b1) $display("[TB] FAIL ctn_r1_valid_c2: got %b want 1", bus.i_r1_valid); else nPass++;
        nTotal++; if (bus.i_r1_data !== 32'h01234567) $display("[TB] FAIL ctn_r1_data_c2: got %h want 01234567", bus.i_r1_data); else nPass++;
        nTotal++; if (bus.i_r0_valid !== 1'b0) $display("[TB] FAIL ctn_r0_valid_c2: got %b want 0", bus.i_r0_valid); else nPass++;
        @(negedge clk);
        #2;
        nTotal++; if (bus.i_r1_valid !== 1'b0) $display("[TB] FAIL ctn_r1_valid_c3: got %b want 0", bus.i_r1_valid); else nPass++;
    endtask

    task automatic test_masked_write();
        @(negedge clk);
        bus.t_r1_valid = 1'b1; bus.t_r1_we = 1'b1; bus.t_r1_addr = 15'h0040;
        bus.t_r1_data = 32'hAABBCCDD; bus.t_r1_mask = 4'b0011;
        #2;
        nTotal++; if (bus.t_r1_ready !== 1'b1) $display("[TB] FAIL mw_ready: got %b want 1", bus.t_r1_ready); else nPass++;
        nTotal++; if (bus.i_mem_mask !== 4'b0011) $display("[TB] FAIL mw_mask: got %b want 0011", bus.i_mem_mask); else nPass++;
        @(negedge clk);
        bus.t_r1_we = 1'b0; bus.t_r1_mask = 4'hF;
        #2;
        nTotal++; if (bus.i_r1_valid !== 1'b0) $display("[TB] FAIL mw_no_wr_rsp: got %b want 0", bus.i_r1_valid); else nPass++;
        @(negedge clk);
        bus.t_r1_valid = 1'b0;
        #2;
        nTotal++; if (bus.i_r1_valid !== 1'b1) $display("[TB] FAIL mw_rd_valid: got %b want 1", bus.i_r1_valid); else nPass++;
        nTotal++; if (bus.i_r1_data !== 32'h1122CCDD) $display("[TB] FAIL mw_rd_data: got %h want 1122ccdd", bus.i_r1_data); else nPass++;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.t_r0_valid = 1'b1; bus.t_r0_we = 1'b0; bus.t_r0_addr = 15'h0080; bus.i_r0_ready = 1'b0;
        #2;
        nTotal++; if (bus.t_r0_ready !== 1'b1) $display("[TB] FAIL bp_first_ready: got %b want 1", bus.t_r0_ready); else nPass++;
        @(negedge clk);
        bus.t_r0_addr = 15'h0084;
        bus.t_r1_valid = 1'b1; bus.t_r1_we = 1'b0; bus.t_r1_addr = 15'h0090;
        #2;
        nTotal++; if (bus.i_r0_data !== 32'hCAFEF00D) $display("[TB] FAIL bp_data_s1: got %h want cafef00d", bus.i_r0_data); else nPass++;
        nTotal++; if (bus.t_r0_ready !== 1'b0) $display("[TB] FAIL bp_stall_s1: got %b want 0", bus.t_r0_ready); else nPass++;
        nTotal++; if (bus.t_r1_ready !== 1'b1) $display("[TB] FAIL bp_r1_ready: got %b want 1", bus.t_r1_ready); else nPass++;
        @(negedge clk);
        bus.t_r1_valid = 1'b0;
        #2;
        nTotal++; if (bus.i_r0_valid !== 1'b1) $display("[TB] FAIL bp_valid_s2: got %b want 1", bus.i_r0_valid); else nPass++;
        nTotal++; if (bus.i_r0_data !== 32'hCAFEF00D) $display("[TB] FAIL bp_data_s2: got %h want cafef00d", bus.i_r0_data); else nPass++;
        nTotal++; if (bus.t_r0_ready !== 1'b0) $display("[TB] FAIL bp_stall_s2: got %b want 0", bus.t_r0_ready); else nPass++;
        nTotal++; if (bus.i_r1_data !== 32'h0BADC0DE) $display("[TB] FAIL bp_r1_data: got %h want 0badc0de", bus.i_r1_data); else nPass++;
        @(negedge clk);
        bus.i_r0_ready = 1'b1;
        #2;
        nTotal++; if (bus.i_r0_data !== 32'hCAFEF00D) $display("[TB] FAIL bp_release_data: got %h want cafef00d", bus.i_r0_data); else nPass++;
        nTotal++; if (bus.t_r0_ready !== 1'b0) $display("[TB] FAIL bp_release_stall: got %b want 0", bus.t_r0_ready); else nPass++;
        @(negedge clk);
        #2;
        nTotal++; if (bus.i_r0_valid !== 1'b0) $display("[TB] FAIL bp_once: got %b want 0", bus.i_r0_valid); else nPass++;
        nTotal++; if (bus.t_r0_ready !== 1'b1) $display("[TB] FAIL bp_next_ready: got %b want 1", bus.t_r0_ready); else nPass++;
        @(negedge clk);
        bus.t_r0_valid = 1'b0;
        #2;
        nTotal++; if (bus.i_r0_data !== 32'h12345678) $display("[TB] FAIL bp_next_data: got %h want 12345678", bus.i_r0_data); else nPass++;
    endtask

    task automatic test_fixed_priority();
        logic expR0;
        @(negedge clk);
        idleReqs();
        rstf = 1'b0;
        @(negedge clk);
        rstf = 1'b1;
        bus.t_r0_valid = 1'b1; bus.t_r0_we = 1'b1; bus.t_r0_addr = 15'h0100; bus.t_r0_data = 32'h0A0A0A0A;
        bus.t_r1_valid = 1'b1; bus.t_r1_we = 1'b1; bus.t_r1_addr = 15'h0104; bus.t_r1_data = 32'h0B0B0B0B;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #2;
`ifdef MEM_ARB_RR_EN
            expR0 = (c % 2 == 0);
`else
            expR0 = 1'b1;
`endif
            nTotal++; if (bus.t_r0_ready !== expR0) $display("[TB] FAIL prio_r0_ready c%0d: got %b want %b", c, bus.t_r0_ready, expR0); else nPass++;
            nTotal++; if (bus.t_r1_ready !== !expR0) $display("[TB] FAIL prio_r1_ready c%0d: got %b want %b", c, bus.t_r1_ready, !expR0); else nPass++;
        end
        @(negedge clk);
        idleReqs();
    endtask

    task automatic test_reset_during_read();
        @(negedge clk);
        bus.t_r0_valid = 1'b1; bus.t_r0_we = 1'b0; bus.t_r0_addr = 15'h00A0;
        #2;
        nTotal++; if (bus.t_r0_ready !== 1'b1) $display("[TB] FAIL rdr_issue: got %b want 1", bus.t_r0_ready); else nPass++;
        @(negedge clk);
        bus.t_r0_valid = 1'b0;
        rstf = 1'b0;
        #2;
        nTotal++; if (bus.i_r0_valid !== 1'b0) $display("[TB] FAIL rdr_in_reset: got %b want 0", bus.i_r0_valid); else nPass++;
        @(negedge clk);
        rstf = 1'b1;
        #2;
        nTotal++; if (bus.i_r0_valid !== 1'b0) $display("[TB] FAIL rdr_after_reset: got %b want 0", bus.i_r0_valid); else nPass++;
        @(negedge clk);
        bus.t_r0_valid = 1'b1;
        #2;
        nTotal++; if (bus.t_r0_ready !== 1'b1) $display("[TB] FAIL rdr_reissue: got %b want 1", bus.t_r0_ready); else nPass++;
        @(negedge clk);
        bus.t_r0_valid = 1'b0;
        #2;
        nTotal++; if (bus.i_r0_valid !== 1'b1) $display("[TB] FAIL rdr_rsp_valid: got %b want 1", bus.i_r0_valid); else nPass++;
        nTotal++; if (bus.i_r0_data !== 32'h5A5A5A5A) $display("[TB] FAIL rdr_rsp_data: got %h want 5a5a5a5a", bus.i_r0_data); else nPass++;
    endtask

    initial begin
        nPass = 0;
        nTotal = 0;
        rstf = 1'b0;
        preEn = 1'b0; preAddr = '0; preData = '0;
        bus.i_mem_ready = 1'b1;
        idleReqs();
        $display("[TB] starting mem_port_arb bench");
        initMemory();
        test_reset();
        test_contending_reads();
        test_masked_write();
        test_backpressure();
        test_fixed_priority();
        test_reset_during_read();
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
